float_multiplier_fp32: RTL and testbench

Pipelined IEEE 754 single-precision multiplier with one registered output stage. It sits in the arithmetic datapath and accepts one operand pair per clock. It produces the rounded product, with flush-to-zero handling of subnormals and full special-value handling (NaN, Inf, zero). It is a drop-in registered replacement for the combinational `float_multiplier` interface: ports `a`, `b`, `result`, plus clock, reset and valid.

---
 rtl/float_multiplier_fp32_if.sv | 10 +
 rtl/float_multiplier_fp32.sv | 52 +++++
 tb/tb_float_multiplier_fp32.sv | 132 +++++++++++++
 3 files changed

// File: rtl/float_multiplier_fp32_if.sv
// float_multiplier_fp32_if: operand/result bundle for the registered fp32 multiplier
interface float_multiplier_fp32_if;
  logic        valid_in;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        valid_out;
  modport master (output valid_in, a, b, input result, valid_out);
  modport slave (input valid_in, a, b, output result, valid_out);
endinterface

// File: rtl/float_multiplier_fp32.sv
// float_multiplier_fp32: binary32 multiply, RNE rounding, flush-to-zero, one output register
module float_multiplier_fp32 (
  input  logic                    clk,
  input  logic                    rst_n,
  float_multiplier_fp32_if.slave  bus
);
  logic        s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic        norm, guard, sticky, rnd, ovf, unf;
  logic [47:0] prod;
  logic [22:0] mant;
  logic [23:0] mant_r;
  logic [9:0]  e_n;
  logic [31:0] result_d, result_q;
  logic        valid_q;
  always_comb begin
    s      = bus.a[31] ^ bus.b[31];
    a_zero = bus.a[30:23] == 8'h00;
    b_zero = bus.b[30:23] == 8'h00;
    a_inf  = bus.a[30:23] == 8'hFF && bus.a[22:0] == 23'h0;
    b_inf  = bus.b[30:23] == 8'hFF && bus.b[22:0] == 23'h0;
    a_nan  = bus.a[30:23] == 8'hFF && bus.a[22:0] != 23'h0;
    b_nan  = bus.b[30:23] == 8'hFF && bus.b[22:0] != 23'h0;
    prod   = {24'h0, 1'b1, bus.a[22:0]} * {24'h0, 1'b1, bus.b[22:0]};
    norm   = prod[47];
    mant   = norm ? prod[46:24] : prod[45:23];
    guard  = norm ? prod[23] : prod[22];
    sticky = norm ? |prod[22:0] : |prod[21:0];
    rnd    = guard & (sticky | mant[0]);
    mant_r = {1'b0, mant} + {23'h0, rnd};
    // 10-bit two's complement exponent; bit 9 flags a negative (underflowed) value
    e_n    = {2'b0, bus.a[30:23]} + {2'b0, bus.b[30:23]} + {9'h0, norm} + {9'h0, mant_r[23]} - 10'd127;
    ovf    = !e_n[9] && e_n >= 10'd255;
    unf    = e_n[9] || e_n == 10'd0;
    result_d = (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) ? 32'h7FC00000 :
               (a_inf || b_inf)   ? {s, 8'hFF, 23'h0} :
               (a_zero || b_zero) ? {s, 31'h0} :
               ovf                ? {s, 8'hFF, 23'h0} :
               unf                ? {s, 31'h0} :
                                    {s, e_n[7:0], mant_r[22:0]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= 32'h0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= bus.valid_in;
      if (bus.valid_in) result_q <= result_d;
    end
  end
  assign bus.result    = result_q;
  assign bus.valid_out = valid_q;
endmodule

// File: tb/tb_float_multiplier_fp32.sv
// tb_float_multiplier_fp32: directed vectors plus a real-arithmetic reference model
module tb_float_multiplier_fp32;
  logic clk, rst_n;
  int   errors = 0, checks = 0;
  logic [31:0] m_res;
  logic        m_v;
  float_multiplier_fp32_if bus();
  float_multiplier_fp32 dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic real to_real(input logic [31:0] x);
    return $bitstoreal({1'b0, {3'b0, x[30:23]} + 11'd896, x[22:0], 29'b0});
  endfunction
  // Product of two binary32 values is exact in a double; then round that double to binary32
  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y);
    logic s, zx, zy, ix, iy;
    logic [63:0] d;
    logic [52:0] m;
    logic [28:0] r;
    logic [24:0] k;
    int e;
    s  = x[31] ^ y[31];
    zx = x[30:23] == 0;
    zy = y[30:23] == 0;
    ix = x[30:23] == 8'hFF;
    iy = y[30:23] == 8'hFF;
    if ((ix && x[22:0] != 0) || (iy && y[22:0] != 0)) return 32'h7FC00000;
    if ((ix && zy) || (iy && zx)) return 32'h7FC00000;
    if (ix || iy) return {s, 8'hFF, 23'h0};
    if (zx || zy) return {s, 31'h0};
    d = $realtobits(to_real(x) * to_real(y));
    e = int'(d[62:52]) - 1023 + 127;
    m = {1'b1, d[51:0]};
    k = {1'b0, m[52:29]};
    r = m[28:0];
    if (r > 29'h10000000 || (r == 29'h10000000 && k[0])) k = k + 25'd1;
    if (k[24]) begin
      k = k >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, e[7:0], k[22:0]};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_res <= 32'h0;
      m_v   <= 1'b0;
    end else begin
      m_v <= bus.valid_in;
      if (bus.valid_in) m_res <= model(bus.a, bus.b);
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmp_valid", {31'h0, bus.valid_out}, {31'h0, m_v});
      chk("cmp_result", bus.result, m_res);
    end
  end
  task automatic run(input string name, input logic [31:0] x, input logic [31:0] y, input logic [31:0] exp);
    @(negedge clk);
    bus.a = x;
    bus.b = y;
    bus.valid_in = 1'b1;
    @(posedge clk);
    #1;
    chk(name, bus.result, exp);
    chk({name, "_valid"}, {31'h0, bus.valid_out}, 32'h1);
    chk({name, "_model"}, model(x, y), exp);
  endtask
  logic [31:0] va [14] = '{32'h3F800000, 32'hBFC00000, 32'h7F800000, 32'h7FC00000, 32'h7F800000,
                           32'hFF800000, 32'h00400000, 32'h00800000, 32'h80400000, 32'h7F7FFFFF,
                           32'h3F800001, 32'h3FFFFFFF, 32'h3FC00000, 32'h00000000};
  logic [31:0] vb [14] = '{32'h40000000, 32'h3F000000, 32'h00000000, 32'h3F800000, 32'h7F800000,
                           32'h40000000, 32'h00200000, 32'h00800000, 32'h3F800000, 32'h40000000,
                           32'h3F800001, 32'h3FFFFFFF, 32'h3FC00000, 32'hFF800000};
  logic [31:0] ve [14] = '{32'h40000000, 32'hBF400000, 32'h7FC00000, 32'h7FC00000, 32'h7F800000,
                           32'hFF800000, 32'h00000000, 32'h00000000, 32'h80000000, 32'h7F800000,
                           32'h3F800002, 32'h407FFFFE, 32'h40100000, 32'h7FC00000};
  initial begin
    clk = 1'b0;
    rst_n = 1'b1;
    bus.valid_in = 1'b0;
    bus.a = 32'h0;
    bus.b = 32'h0;
    #2 rst_n = 1'b0;
    #5;
    chk("reset_result", bus.result, 32'h0);
    chk("reset_valid", {31'h0, bus.valid_out}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) run($sformatf("vec%0d", i), va[i], vb[i], ve[i]);
    @(negedge clk);
    bus.valid_in = 1'b0;
    bus.a = 32'h40400000;
    bus.b = 32'h40400000;
    @(posedge clk);
    #1;
    chk("hold_result", bus.result, 32'h7FC00000);
    chk("hold_valid", {31'h0, bus.valid_out}, 32'h0);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      bus.a = {$urandom_range(1, 0), 8'($urandom_range(96, 160)), 23'($urandom)};
      bus.b = {$urandom_range(1, 0), 8'($urandom_range(96, 160)), 23'($urandom)};
      bus.valid_in = 1'($urandom_range(3, 0) != 0);
    end
    run("pre_reset", 32'h40400000, 32'h40400000, 32'h41100000);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_result", bus.result, 32'h0);
    chk("async_rst_valid", {31'h0, bus.valid_out}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.valid_in = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_valid", {31'h0, bus.valid_out}, 32'h0);
    chk("post_rst_result", bus.result, 32'h0);
    run("post_rst_op", 32'hC0000000, 32'h40800000, 32'hC1000000);
    @(negedge clk);
    bus.valid_in = 1'b0;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
